fetch_unit: RTL and testbench

- Instruction-fetch stage directly upstream of the hazard controller's stall/flush consumers.
- Owns the PC, runs a request/acknowledge handshake with instruction memory, and loads the fetch→decode pipeline register.
- Honours f_stall/d_stall from the hazard controller and accepts PC redirects (branch/jump) from decode.
- Provides a one-entry hold buffer so a response that returns while decode is stalled is never lost.

---
 rtl/global_types.sv | 22 ++
 rtl/fetch_hold_buffer.sv | 50 +++++
 rtl/fetch_unit.sv | 188 ++++++++++++++++++
 tb/tb_fetch_unit.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/global_types.sv
`default_nettype none
// ============================================================================
// Module   : global_types
// Summary  : Shared widths, reset defaults and state type for the fetch stage.
// Revision : 1.0
// ============================================================================
package global_types;

   localparam int INSTR_W = 32;

   localparam logic [31:0]        DEFAULT_RESET_PC  = 32'h0000_0000;
   localparam logic [INSTR_W-1:0] DEFAULT_NOP_INSTR = 32'h0000_0000;

   typedef enum logic [1:0] {
      BOOT = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2,
      HOLD = 2'd3
   } fetch_state_t;

endpackage
`default_nettype wire

// File: rtl/fetch_hold_buffer.sv
`default_nettype none
// ============================================================================
// Module   : fetch_hold_buffer
// Summary  : One-entry parking register for a fetched word while decode stalls.
// Revision : 1.0
// ============================================================================
module fetch_hold_buffer
   import global_types::*;
(
   input  logic               clk_i,
   input  logic               reset_i,
   input  logic               load_i,
   input  logic               clear_i,
   input  logic               consume_i,
   input  logic [INSTR_W-1:0] instr_i,
   input  logic [31:0]        pc_plus4_i,
   output logic [INSTR_W-1:0] instr_o,
   output logic [31:0]        pc_plus4_o,
   output logic               valid_o
);

   logic [INSTR_W-1:0] instr_q;
   logic [31:0]        pc_plus4_q;
   logic               valid_q;

   // Clear (redirect) outranks a same-cycle load.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         instr_q    <= '0;
         pc_plus4_q <= '0;
         valid_q    <= 1'b0;
      end else if (clear_i) begin
         instr_q    <= '0;
         pc_plus4_q <= '0;
         valid_q    <= 1'b0;
      end else if (load_i) begin
         instr_q    <= instr_i;
         pc_plus4_q <= pc_plus4_i;
         valid_q    <= 1'b1;
      end else if (consume_i) begin
         valid_q    <= 1'b0;
      end
   end

   assign instr_o    = instr_q;
   assign pc_plus4_o = pc_plus4_q;
   assign valid_o    = valid_q;

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : fetch_unit
// Summary  : PC owner, imem handshake and fetch->decode register with a hold
//            buffer. Define FETCH_PERF_CNT_EN to add wait/redirect counters.
// Revision : 1.0
// ============================================================================
module fetch_unit
   import global_types::*;
#(
   parameter logic [31:0]        RESET_PC  = DEFAULT_RESET_PC,
   parameter logic [INSTR_W-1:0] NOP_INSTR = DEFAULT_NOP_INSTR
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               f_stall,
   input  logic               d_stall,
   input  logic               redirect_valid,
   input  logic [31:0]        redirect_pc,
   output logic               imem_req,
   output logic [31:0]        imem_addr,
   input  logic               imem_ack,
   input  logic [INSTR_W-1:0] imem_rdata,
   output logic [31:0]        f_pc,
   output logic [INSTR_W-1:0] d_instr,
   output logic [31:0]        d_pc_plus4,
   output logic               d_valid,
   output logic               fetch_busy
`ifdef FETCH_PERF_CNT_EN
   ,
   output logic [31:0]        perf_wait_cycles,
   output logic [31:0]        perf_redirects
`endif
);

   fetch_state_t       state_q;
   logic [31:0]        pc_q;
   logic [31:0]        addr_q;
   logic               kill_q;

   logic [INSTR_W-1:0] d_instr_q, d_instr_d;
   logic [31:0]        d_pc_plus4_q, d_pc_plus4_d;
   logic               d_valid_q, d_valid_d;

   logic [31:0]        w_redirect_tgt;
   logic [31:0]        w_pc_plus4;
   logic               w_capture;
   logic               w_release;
   logic [INSTR_W-1:0] w_hb_instr;
   logic [31:0]        w_hb_pc_plus4;
   logic               w_hb_valid;
   logic               w_unused_pc_lsbs;

   assign w_redirect_tgt   = {redirect_pc[31:2], 2'b00};
   assign w_unused_pc_lsbs = ^redirect_pc[1:0];
   assign w_pc_plus4       = pc_q + 32'd4;

   // WAIT keeps the request up even under f_stall; addr_q pins the address
   // there because pc_q may already point at a redirect target.
   assign imem_req   = (state_q == WAIT) || ((state_q == REQ) && !f_stall);
   assign imem_addr  = (state_q == WAIT) ? addr_q : pc_q;
   assign fetch_busy = (state_q == WAIT) || ((state_q == REQ) && !f_stall && !imem_ack);

   assign w_capture = imem_req && imem_ack && !kill_q && !redirect_valid;
   assign w_release = (state_q == HOLD) && w_hb_valid && !d_stall && !redirect_valid;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= BOOT;
         pc_q    <= RESET_PC;
         addr_q  <= RESET_PC;
         kill_q  <= 1'b0;
      end else if (redirect_valid) begin
         pc_q <= w_redirect_tgt;
         if (imem_req && !imem_ack) begin
            state_q <= WAIT;
            addr_q  <= imem_addr;
            kill_q  <= 1'b1;
         end else begin
            state_q <= REQ;
            kill_q  <= 1'b0;
         end
      end else begin
         case (state_q)
            BOOT: state_q <= REQ;
            REQ: begin
               if (imem_req) begin
                  if (imem_ack) begin
                     pc_q    <= w_pc_plus4;
                     state_q <= d_stall ? HOLD : REQ;
                  end else begin
                     addr_q  <= pc_q;
                     state_q <= WAIT;
                  end
               end
            end
            WAIT: begin
               if (imem_ack) begin
                  kill_q <= 1'b0;
                  if (kill_q) begin
                     state_q <= REQ;
                  end else begin
                     pc_q    <= w_pc_plus4;
                     state_q <= d_stall ? HOLD : REQ;
                  end
               end
            end
            HOLD: begin
               if (!d_stall) state_q <= REQ;
            end
            default: state_q <= BOOT;
         endcase
      end
   end

   fetch_hold_buffer u_hold (
      .clk_i      (clk),
      .reset_i    (reset),
      .load_i     (w_capture && d_stall),
      .clear_i    (redirect_valid),
      .consume_i  (w_release),
      .instr_i    (imem_rdata),
      .pc_plus4_i (w_pc_plus4),
      .instr_o    (w_hb_instr),
      .pc_plus4_o (w_hb_pc_plus4),
      .valid_o    (w_hb_valid)
   );

   always_comb begin
      d_instr_d    = d_instr_q;
      d_pc_plus4_d = d_pc_plus4_q;
      d_valid_d    = d_valid_q;
      if (redirect_valid || !d_stall) begin
         if (w_capture) begin
            d_instr_d    = imem_rdata;
            d_pc_plus4_d = w_pc_plus4;
            d_valid_d    = 1'b1;
         end else if (w_release) begin
            d_instr_d    = w_hb_instr;
            d_pc_plus4_d = w_hb_pc_plus4;
            d_valid_d    = 1'b1;
         end else begin
            d_instr_d    = NOP_INSTR;
            d_pc_plus4_d = '0;
            d_valid_d    = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         d_instr_q    <= NOP_INSTR;
         d_pc_plus4_q <= '0;
         d_valid_q    <= 1'b0;
      end else begin
         d_instr_q    <= d_instr_d;
         d_pc_plus4_q <= d_pc_plus4_d;
         d_valid_q    <= d_valid_d;
      end
   end

   assign f_pc       = pc_q;
   assign d_instr    = d_instr_q;
   assign d_pc_plus4 = d_pc_plus4_q;
   assign d_valid    = d_valid_q;

`ifdef FETCH_PERF_CNT_EN
   logic [31:0] perf_wait_q;
   logic [31:0] perf_redir_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         perf_wait_q  <= '0;
         perf_redir_q <= '0;
      end else begin
         if (fetch_busy && (perf_wait_q != 32'hFFFF_FFFF))
            perf_wait_q <= perf_wait_q + 32'd1;
         if (redirect_valid && (perf_redir_q != 32'hFFFF_FFFF))
            perf_redir_q <= perf_redir_q + 32'd1;
      end
   end

   assign perf_wait_cycles = perf_wait_q;
   assign perf_redirects   = perf_redir_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_unit
// Summary  : Self-checking bench for fetch_unit: directed scenarios plus a
//            randomized run against a transaction-level reference model.
// Revision : 1.0
// ============================================================================
module tb_fetch_unit;

   localparam logic [31:0] c_NOP = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        f_stall = 1'b0, d_stall = 1'b0, redirect_valid = 1'b0;
   logic [31:0] redirect_pc = '0;
   logic        imem_ack = 1'b0;
   logic [31:0] imem_rdata = '0;
   logic        imem_req, d_valid, fetch_busy;
   logic [31:0] imem_addr, f_pc, d_instr, d_pc_plus4;

   logic        wr_req, wr_valid, wr_busy;
   logic [31:0] wr_addr, wr_fpc, wr_instr, wr_pc4, wr_rdata;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   function automatic logic [31:0] word_at(input logic [31:0] a);
      return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
   endfunction

   assign wr_rdata = word_at(wr_addr);

`ifdef FETCH_PERF_CNT_EN
   logic [31:0] perf_w, perf_r;
`endif

   fetch_unit u_dut (
      .clk(clk), .reset(reset), .f_stall(f_stall), .d_stall(d_stall),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
      .imem_rdata(imem_rdata), .f_pc(f_pc), .d_instr(d_instr),
      .d_pc_plus4(d_pc_plus4), .d_valid(d_valid), .fetch_busy(fetch_busy)
`ifdef FETCH_PERF_CNT_EN
      , .perf_wait_cycles(perf_w), .perf_redirects(perf_r)
`endif
   );

   // Zero-wait instance booting just below the wrap point.
   fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) u_dut_wrap (
      .clk(clk), .reset(reset), .f_stall(1'b0), .d_stall(1'b0),
      .redirect_valid(1'b0), .redirect_pc(32'h0),
      .imem_req(wr_req), .imem_addr(wr_addr), .imem_ack(wr_req),
      .imem_rdata(wr_rdata), .f_pc(wr_fpc), .d_instr(wr_instr),
      .d_pc_plus4(wr_pc4), .d_valid(wr_valid), .fetch_busy(wr_busy)
`ifdef FETCH_PERF_CNT_EN
      , .perf_wait_cycles(), .perf_redirects()
`endif
   );

   // ---------------- reference model (transaction level) ----------------
   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc4;
   } held_t;

   bit          m_boot, m_out, m_killed, m_d_valid;
   logic [31:0] m_pc, m_out_addr, m_d_instr, m_d_pc4;
   held_t       m_held[$];

   task automatic model_reset();
      m_boot = 1; m_out = 0; m_killed = 0; m_pc = 32'h0; m_out_addr = 32'h0;
      m_held.delete();
      m_d_instr = c_NOP; m_d_pc4 = 32'h0; m_d_valid = 0;
   endtask

   task automatic model_step(input bit ds, input bit rv, input logic [31:0] rpc,
                             input bit req, input bit ack,
                             input logic [31:0] addr, input logic [31:0] rdata);
      bit    fetched;
      held_t h;
      fetched = req && ack && !m_killed;
      m_boot  = 0;
      if (rv) begin
         m_held.delete();
         m_d_instr = c_NOP; m_d_pc4 = 32'h0; m_d_valid = 0;
         m_killed = req && !ack; m_out = m_killed; m_out_addr = addr;
         m_pc = {rpc[31:2], 2'b00};
      end else begin
         if (req && ack) begin m_out = 0; m_killed = 0; end
         else if (req) begin m_out = 1; m_out_addr = addr; end
         if (fetched) begin
            m_pc = m_pc + 32'd4;
            if (ds) m_held.push_back('{instr: rdata, pc4: m_pc});
            else begin m_d_instr = rdata; m_d_pc4 = m_pc; m_d_valid = 1; end
         end else if (!ds) begin
            if (m_held.size() != 0) begin
               h = m_held.pop_front();
               m_d_instr = h.instr; m_d_pc4 = h.pc4; m_d_valid = 1;
            end else begin
               m_d_instr = c_NOP; m_d_pc4 = 32'h0; m_d_valid = 0;
            end
         end
      end
   endtask

   // ---------------- stimulus helpers ----------------
   task automatic do_reset();
      @(negedge clk);
      reset = 1; f_stall = 0; d_stall = 0; redirect_valid = 0; redirect_pc = 0;
      imem_ack = 0; imem_rdata = 0;
      @(posedge clk);
      #2 reset = 0;
   endtask

   task automatic drive(input bit fs, input bit ds, input bit rv,
                        input logic [31:0] rpc, input bit ack_ok);
      @(negedge clk);
      f_stall = fs; d_stall = ds; redirect_valid = rv; redirect_pc = rpc; imem_ack = 0;
      #1;
      imem_ack   = ack_ok && imem_req;
      imem_rdata = word_at(imem_addr);
      #1;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      do_reset();
      #1;
      checks++; if (d_valid !== 1'b0) begin errors++; $display("FAIL reset_d_valid got=%h exp=0", d_valid); end
      checks++; if (d_instr !== c_NOP) begin errors++; $display("FAIL reset_d_instr got=%h exp=%h", d_instr, c_NOP); end
      checks++; if (d_pc_plus4 !== 32'h0) begin errors++; $display("FAIL reset_d_pc_plus4 got=%h exp=0", d_pc_plus4); end
      checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_imem_req got=%h exp=0", imem_req); end
      checks++; if (fetch_busy !== 1'b0) begin errors++; $display("FAIL reset_fetch_busy got=%h exp=0", fetch_busy); end
      checks++; if (f_pc !== 32'h0) begin errors++; $display("FAIL reset_f_pc got=%h exp=0", f_pc); end
   endtask

   task automatic test_zero_wait();
      bit          ev[4] = '{1'b0, 1'b1, 1'b1, 1'b1};
      logic [31:0] ep[4] = '{32'h0, 32'h4, 32'h8, 32'hC};
      do_reset();
      for (int k = 0; k < 4; k++) begin
         drive(0, 0, 0, 32'h0, 1);
         if (k == 0) begin
            checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL zw_boot_req got=%h exp=0", imem_req); end
         end
         tick();
         checks++; if (d_valid !== ev[k]) begin errors++; $display("FAIL zw_d_valid k=%0d got=%h exp=%h", k, d_valid, ev[k]); end
         if (ev[k]) begin
            checks++; if (d_pc_plus4 !== ep[k]) begin errors++; $display("FAIL zw_pc4 k=%0d got=%h exp=%h", k, d_pc_plus4, ep[k]); end
            checks++; if (d_instr !== word_at(ep[k] - 32'd4)) begin errors++; $display("FAIL zw_instr k=%0d got=%h exp=%h", k, d_instr, word_at(ep[k] - 32'd4)); end
         end
      end
   endtask

   task automatic test_two_cycle_ack();
      do_reset();
      drive(0, 0, 0, 32'h0, 0); tick();
      drive(0, 0, 0, 32'h0, 0);
      checks++; if ({imem_req, fetch_busy} !== 2'b11) begin errors++; $display("FAIL lat2_req_busy1 got=%b exp=11", {imem_req, fetch_busy}); end
      checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL lat2_addr1 got=%h exp=0", imem_addr); end
      tick();
      checks++; if (d_valid !== 1'b0) begin errors++; $display("FAIL lat2_bubble got=%h exp=0", d_valid); end
      drive(1, 0, 0, 32'h0, 1);
      checks++; if ({imem_req, fetch_busy} !== 2'b11) begin errors++; $display("FAIL lat2_req_busy2 got=%b exp=11", {imem_req, fetch_busy}); end
      checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL lat2_addr2 got=%h exp=0", imem_addr); end
      tick();
      checks++; if ({d_valid, d_pc_plus4} !== {1'b1, 32'h4}) begin errors++; $display("FAIL lat2_capture got=%b/%h exp=1/4", d_valid, d_pc_plus4); end
   endtask

   task automatic test_hold();
      do_reset();
      for (int k = 0; k < 5; k++) begin drive(0, 0, 0, 32'h0, 1); tick(); end
      drive(0, 1, 0, 32'h0, 1);
      checks++; if (f_pc !== 32'h10) begin errors++; $display("FAIL hold_pc got=%h exp=10", f_pc); end
      tick();
      for (int k = 0; k < 2; k++) begin
         drive(0, 1, 0, 32'h0, 1);
         checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL hold_req k=%0d got=%h exp=0", k, imem_req); end
         tick();
         checks++; if ({d_valid, d_pc_plus4, d_instr} !== {1'b1, 32'h10, word_at(32'hC)}) begin
            errors++; $display("FAIL hold_frozen k=%0d got=%b/%h/%h exp=1/10/%h", k, d_valid, d_pc_plus4, d_instr, word_at(32'hC)); end
      end
      drive(0, 0, 0, 32'h0, 1); tick();
      checks++; if ({d_valid, d_pc_plus4, d_instr} !== {1'b1, 32'h14, word_at(32'h10)}) begin
         errors++; $display("FAIL hold_release got=%b/%h/%h exp=1/14/%h", d_valid, d_pc_plus4, d_instr, word_at(32'h10)); end
      drive(0, 0, 0, 32'h0, 0);
      checks++; if ({imem_req, imem_addr} !== {1'b1, 32'h14}) begin errors++; $display("FAIL hold_next_req got=%b/%h exp=1/14", imem_req, imem_addr); end
   endtask

   task automatic test_redirect_wait();
      do_reset();
      drive(0, 0, 0, 32'h0, 0); tick();
      drive(0, 0, 0, 32'h0, 0); tick();
      drive(0, 0, 1, 32'h0000_0103, 0);
      checks++; if ({fetch_busy, imem_addr} !== {1'b1, 32'h0}) begin errors++; $display("FAIL rdw_wait got=%b/%h exp=1/0", fetch_busy, imem_addr); end
      tick();
      checks++; if ({f_pc, d_valid} !== {32'h100, 1'b0}) begin errors++; $display("FAIL rdw_pc got=%h/%b exp=100/0", f_pc, d_valid); end
      drive(0, 0, 0, 32'h0, 0);
      checks++; if ({imem_req, imem_addr} !== {1'b1, 32'h0}) begin errors++; $display("FAIL rdw_held_addr got=%b/%h exp=1/0", imem_req, imem_addr); end
      tick();
      drive(0, 0, 0, 32'h0, 1); tick();
      checks++; if ({d_valid, f_pc} !== {1'b0, 32'h100}) begin errors++; $display("FAIL rdw_killed got=%b/%h exp=0/100", d_valid, f_pc); end
      drive(0, 0, 0, 32'h0, 1);
      checks++; if ({imem_req, imem_addr} !== {1'b1, 32'h100}) begin errors++; $display("FAIL rdw_new_req got=%b/%h exp=1/100", imem_req, imem_addr); end
      tick();
      checks++; if ({d_valid, d_pc_plus4} !== {1'b1, 32'h104}) begin errors++; $display("FAIL rdw_first got=%b/%h exp=1/104", d_valid, d_pc_plus4); end
   endtask

   task automatic test_redirect_ack();
      do_reset();
      drive(0, 0, 0, 32'h0, 0); tick();
      drive(0, 0, 0, 32'h0, 0); tick();
      drive(1, 0, 1, 32'h2000_0042, 1);
      checks++; if ({imem_req, imem_ack} !== 2'b11) begin errors++; $display("FAIL rda_wait_req got=%b exp=11", {imem_req, imem_ack}); end
      tick();
      checks++; if ({f_pc, d_valid} !== {32'h2000_0040, 1'b0}) begin errors++; $display("FAIL rda_pc got=%h/%b exp=20000040/0", f_pc, d_valid); end
      drive(1, 0, 0, 32'h0, 1);
      checks++; if ({imem_req, fetch_busy} !== 2'b00) begin errors++; $display("FAIL rda_fstall got=%b exp=00", {imem_req, fetch_busy}); end
      tick();
      drive(0, 0, 0, 32'h0, 1);
      checks++; if ({imem_req, imem_addr} !== {1'b1, 32'h2000_0040}) begin errors++; $display("FAIL rda_req got=%b/%h exp=1/20000040", imem_req, imem_addr); end
      tick();
      checks++; if ({d_valid, d_pc_plus4} !== {1'b1, 32'h2000_0044}) begin errors++; $display("FAIL rda_first got=%b/%h exp=1/20000044", d_valid, d_pc_plus4); end
   endtask

   task automatic test_async_reset();
      do_reset();
      drive(0, 0, 0, 32'h0, 0); tick();
      drive(0, 0, 0, 32'h0, 1); tick();
      drive(0, 1, 0, 32'h0, 0); tick();
      drive(0, 1, 0, 32'h0, 0);
      checks++; if ({fetch_busy, d_valid, f_pc} !== {1'b1, 1'b1, 32'h4}) begin errors++; $display("FAIL ar_pre got=%b/%b/%h exp=1/1/4", fetch_busy, d_valid, f_pc); end
      #1 reset = 1;
      #1;
      checks++; if ({imem_req, fetch_busy, d_valid} !== 3'b000) begin errors++; $display("FAIL ar_ctrl got=%b exp=000", {imem_req, fetch_busy, d_valid}); end
      checks++; if ({f_pc, d_instr, d_pc_plus4} !== {32'h0, c_NOP, 32'h0}) begin errors++; $display("FAIL ar_data got=%h/%h/%h exp=0/%h/0", f_pc, d_instr, d_pc_plus4, c_NOP); end
      @(negedge clk);
      reset = 0; d_stall = 0; imem_ack = 1; imem_rdata = 32'hDEAD_BEEF;
      #1;
      checks++; if ({imem_req, fetch_busy} !== 2'b00) begin errors++; $display("FAIL ar_boot got=%b exp=00", {imem_req, fetch_busy}); end
      tick();
      imem_ack = 0;
      checks++; if ({d_valid, f_pc} !== {1'b0, 32'h0}) begin errors++; $display("FAIL ar_boot_ack got=%b/%h exp=0/0", d_valid, f_pc); end
   endtask

   task automatic test_wrap();
      do_reset();
      drive(0, 0, 0, 32'h0, 0); tick();
      drive(0, 0, 0, 32'h0, 0);
      checks++; if ({wr_req, wr_busy, wr_addr} !== {2'b10, 32'hFFFF_FFFC}) begin errors++; $display("FAIL wrap_req got=%b/%b/%h exp=1/0/fffffffc", wr_req, wr_busy, wr_addr); end
      tick();
      checks++; if ({wr_valid, wr_pc4, wr_instr} !== {1'b1, 32'h0, word_at(32'hFFFF_FFFC)}) begin
         errors++; $display("FAIL wrap_capture got=%b/%h/%h exp=1/0/%h", wr_valid, wr_pc4, wr_instr, word_at(32'hFFFF_FFFC)); end
      checks++; if ({wr_fpc, wr_addr} !== {32'h0, 32'h0}) begin errors++; $display("FAIL wrap_next got=%h/%h exp=0/0", wr_fpc, wr_addr); end
   endtask

   task automatic test_random();
      bit          fs, ds, rv, ack, exp_req, exp_busy, mbusy;
      logic [31:0] rpc, exp_addr, rdata;
      int          lat, cnt;
      do_reset();
      model_reset();
      mbusy = 0; cnt = 0; lat = 1;
      for (int n = 0; n < 3000; n++) begin
         @(negedge clk);
         fs  = ($urandom_range(0, 3) == 0);
         ds  = ($urandom_range(0, 2) == 0);
         rv  = ($urandom_range(0, 11) == 0);
         rpc = $urandom();
         exp_req  = !m_boot && (m_held.size() == 0) && (m_out || !fs);
         exp_addr = m_out ? m_out_addr : m_pc;
         ack = 0;
         if (exp_req) begin
            if (!mbusy) begin mbusy = 1; cnt = 1; lat = $urandom_range(1, 3); end
            else cnt++;
            ack = (cnt >= lat);
         end
         exp_busy = m_out || (exp_req && !ack);
         rdata = ack ? word_at(exp_addr) : $urandom();
         f_stall = fs; d_stall = ds; redirect_valid = rv; redirect_pc = rpc;
         imem_ack = ack; imem_rdata = rdata;
         #1;
         checks++; if (imem_req !== exp_req) begin errors++; $display("FAIL rnd_req n=%0d got=%b exp=%b", n, imem_req, exp_req); end
         if (exp_req) begin
            checks++; if (imem_addr !== exp_addr) begin errors++; $display("FAIL rnd_addr n=%0d got=%h exp=%h", n, imem_addr, exp_addr); end
         end
         checks++; if (fetch_busy !== exp_busy) begin errors++; $display("FAIL rnd_busy n=%0d got=%b exp=%b", n, fetch_busy, exp_busy); end
         checks++; if (f_pc !== m_pc) begin errors++; $display("FAIL rnd_pc n=%0d got=%h exp=%h", n, f_pc, m_pc); end
         checks++; if (d_valid !== m_d_valid) begin errors++; $display("FAIL rnd_d_valid n=%0d got=%b exp=%b", n, d_valid, m_d_valid); end
         if (m_d_valid) begin
            checks++; if ({d_instr, d_pc_plus4} !== {m_d_instr, m_d_pc4}) begin
               errors++; $display("FAIL rnd_d_reg n=%0d got=%h/%h exp=%h/%h", n, d_instr, d_pc_plus4, m_d_instr, m_d_pc4); end
         end
         @(posedge clk);
         model_step(ds, rv, rpc, exp_req, ack, exp_addr, rdata);
         if (ack) mbusy = 0;
      end
   endtask

   initial begin
      test_reset();
      test_zero_wait();
      test_two_cycle_ack();
      test_hold();
      test_redirect_wait();
      test_redirect_ack();
      test_async_reset();
      test_wrap();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
